// File: rtl/riscp_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// opcode field position and default control opcodes.
package riscp_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_ADVANCE = 3'd4,
    S_HALT    = 3'd5
  } seq_state_t;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;

  localparam logic [5:0] JMP_OP_DEF  = 6'h02;
  localparam logic [5:0] HALT_OP_DEF = 6'h3F;

  function automatic logic [5:0] opcode(input logic [31:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute/advance sequencer driving an external program counter
// and execute unit, with fetch timeout and saturating retire count.
module fetch_sequencer
  import riscp_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [5:0]  JMP_OP  = JMP_OP_DEF,
  parameter logic [5:0]  HALT_OP = HALT_OP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [3:0]  pc,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        exec_done,
  output logic        imem_req,
  output logic [3:0]  imem_addr,
  output logic [31:0] ir,
  output logic        exec_start,
  output logic        ldpc,
  output logic        jump,
  output logic        halted,
  output logic        fetch_err,
  output logic [7:0]  retired
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  seq_state_t  state_q, state_d;
  logic        run_q;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  retired_q, retired_d;
  logic        err_q, err_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // run_q resets high so a run level already present out of reset is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b1;
      wait_q    <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run;
      wait_q    <= wait_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    ir_d       = ir_q;
    retired_d  = retired_q;
    err_d      = err_q;
    imem_req   = 1'b0;
    exec_start = 1'b0;
    ldpc       = 1'b0;
    jump       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (run && !run_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // valid wins over a timeout landing on the same cycle
        if (imem_valid) begin
          ir_d    = imem_rdata;
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          wait_d  = '0;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (opcode(ir_q) == HALT_OP) begin
          state_d = S_HALT;
        end else begin
          exec_start = 1'b1;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          retired_d = sat_inc(retired_q);
          state_d   = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        ldpc    = 1'b1;
        jump    = (opcode(ir_q) == JMP_OP);
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_addr = pc;
  assign ir        = ir_q;
  assign halted    = (state_q == S_HALT);
  assign fetch_err = err_q;
  assign retired   = retired_q;

endmodule
